missile_ctrl: RTL and testbench
===============================

MISSILE_CTRL -- requirements
Module: missile_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 8, meaning alien grid columns.
REQ-002 SHALL have parameter ROWS, default 4, meaning alien grid rows; row 0 is the top row.
REQ-003 SHALL have parameter FIELD_H, default 16, meaning playfield height in cells; y=0 is the top cell.
REQ-004 SHALL have parameter STEP_DIV, default 4, meaning ticks per one-cell missile move.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port tick, input, 1 bit: game-rate strobe, one clk wide.
REQ-008 SHALL have port fire_btn, input, 1 bit: player fire button, level.
REQ-009 SHALL have port player_col, input, COL_W bits (COL_W = clog2(COLS)): player column.
REQ-010 SHALL have port grid_top, input, Y_W bits (Y_W = clog2(FIELD_H)): y of alien row 0.
REQ-011 SHALL have port alive_vec, input, ROWS*COLS bits: per-alien alive flags, index = row*COLS+col.
REQ-012 SHALL have port hit, output, ROWS*COLS bits: one-hot kill pulse, wired to each alien's hit input.
REQ-013 SHALL have port miss, output, 1 bit: pulse when the missile leaves the top of the field.
REQ-014 SHALL have port active, output, 1 bit: missile in flight.
REQ-015 SHALL have port m_col, output, COL_W bits: missile column.
REQ-016 SHALL have port m_y, output, Y_W bits: missile row.

Function
REQ-017 SHALL implement FSM states IDLE, FLY and HIT.
REQ-018 SHALL register fire_btn and launch only on its rising edge (fire_btn=1, previous=0) while in IDLE.
REQ-019 SHALL on launch latch m_col=player_col, set m_y=FIELD_H-1, clear the step counter, and enter FLY; active=1 from the next cycle.
REQ-020 SHALL ignore fire edges in FLY and HIT; a button held through flight SHALL NOT relaunch without a new rising edge.
REQ-021 SHALL in FLY count tick pulses; on the STEP_DIV-th tick it SHALL clear the counter and decrement m_y.
REQ-022 SHALL at that same step, if m_y==0, pulse miss for one cycle and enter IDLE instead of decrementing (no wrap).
REQ-023 SHALL evaluate collision every FLY cycle: in range when grid_top <= m_y <= grid_top+ROWS-1, with r=m_y-grid_top and idx=r*COLS+m_col; collision when alive_vec[idx]=1.
REQ-024 SHALL on collision enter HIT and suppress any step in that cycle, since collision has priority over step and miss.
REQ-025 SHALL in HIT assert hit[idx] alone for exactly one cycle, then enter IDLE; active SHALL be low in HIT.
REQ-026 SHALL compute the range check without overflow (width Y_W+1) so that grid_top+ROWS beyond FIELD_H never aliases.
REQ-027 SHALL let a missile pass through dead aliens (alive_vec bit 0) unaffected.
REQ-028 SHALL register all outputs; hit and miss SHALL be low in every state other than their defined pulse cycle.

Reset
REQ-029 SHALL on rst=1 at a clk edge, including mid-flight or during HIT, enter IDLE with hit=0, miss=0, active=0, m_col=0, m_y=0, step counter=0, and fire history=0.
REQ-030 SHALL NOT launch in the first cycle after reset release unless fire_btn rises after release.

Structure
REQ-031 SHALL take COLS, ROWS, FIELD_H and the state enum from the shared package game_pkg, which the alien grid also uses.
REQ-032 SHALL place the tick step counter in the sub-module tick_div (inputs clk, rst, clr, tick; output step).

Verification
REQ-033 SHALL cover hit: defaults, grid_top=2, alive all 1, player_col=3, fire rise -> after 10 steps (40 ticks) m_y=5, then hit[27] high for one cycle, IDLE.
REQ-034 SHALL cover miss: alive all 0, fire rise -> m_y counts 15..0, miss pulses on the 16th step (64 ticks), no hit bit ever set.
REQ-035 SHALL cover pass-through: only alive[27] cleared, col 3 -> missile passes y=5, hits idx 19 at y=4.
REQ-036 SHALL cover fire during flight: extra fire edges and a held button during FLY -> no relaunch; relaunch only after release and press in IDLE.
REQ-037 SHALL cover tick and collision in the same cycle: collision at y=5 with a step tick in that cycle -> hit[27], m_y stays 5, no miss.
REQ-038 SHALL cover reset mid-flight: rst at m_y=9 -> next cycle active=0, m_y=0, hit=0; fire_btn still held -> no launch.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared game constants and types. The alien grid and the player's missile
// controller both take their geometry from here, so the two always agree on
// grid size and playfield height.
//   COLS, ROWS : alien grid dimensions (row 0 is the top row)
//   FIELD_H    : playfield height in cells (y = 0 is the top cell)
//   missile_state_t : missile controller state encoding
// ---------------------------------------------------------------------------
package game_pkg;

   localparam int COLS    = 8;
   localparam int ROWS    = 4;
   localparam int FIELD_H = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      HIT  = 2'd2
   } missile_state_t;

endpackage

// File: rtl/tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// Counts game-rate ticks and flags the STEP_DIV-th one, at which point the
// count restarts. clr holds the count at zero (used whenever no missile is
// in flight, so every flight starts from a fresh count).
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, also masks step
//   tick : one-cycle game-rate strobe
//   step : high in the cycle of the STEP_DIV-th tick
// ---------------------------------------------------------------------------
module tick_div #(
   parameter int STEP_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic step
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign step = tick && !clr && (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clr || step)
         cnt <= '0;
      else if (tick)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/missile_ctrl.sv
// ---------------------------------------------------------------------------
// missile_ctrl
// Player missile: launched on a fire-button rising edge, climbs one cell
// every STEP_DIV ticks, kills the first live alien it overlaps (one-cycle
// one-hot hit pulse) or reports a miss when it leaves the top of the field.
//   clk        : clock
//   rst        : synchronous active-high reset
//   tick       : game-rate strobe
//   fire_btn   : fire button level
//   player_col : player column, latched at launch
//   grid_top   : y of alien row 0
//   alive_vec  : alive flags, index = row*COLS + col
//   hit        : one-hot kill pulse (registered)
//   miss       : missile left the field (registered pulse)
//   active     : missile in flight
//   m_col/m_y  : missile position
// ---------------------------------------------------------------------------
module missile_ctrl #(
   parameter int COLS     = game_pkg::COLS,
   parameter int ROWS     = game_pkg::ROWS,
   parameter int FIELD_H  = game_pkg::FIELD_H,
   parameter int STEP_DIV = 4,
   localparam int COL_W   = $clog2(COLS),
   localparam int Y_W     = $clog2(FIELD_H),
   localparam int N       = ROWS * COLS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             fire_btn,
   input  logic [COL_W-1:0] player_col,
   input  logic [Y_W-1:0]   grid_top,
   input  logic [N-1:0]     alive_vec,
   output logic [N-1:0]     hit,
   output logic             miss,
   output logic             active,
   output logic [COL_W-1:0] m_col,
   output logic [Y_W-1:0]   m_y
);

   import game_pkg::*;

   missile_state_t   state_q, state_d;
   logic             fire_q;
   logic             armed_q;     // a released button has been seen since reset
   logic             step;
   logic             launch;
   logic             in_range;
   logic             collide;
   logic [N-1:0]     target;
   logic [Y_W:0]     y_ext, top_ext, bot_ext, row_off;

   logic [N-1:0]     hit_d;
   logic             miss_d, active_d;
   logic [COL_W-1:0] m_col_d;
   logic [Y_W-1:0]   m_y_d;

   tick_div #(.STEP_DIV(STEP_DIV)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != FLY),
      .tick (tick),
      .step (step)
   );

   // A button held through reset must be released before it can fire, so a
   // rise only counts once armed_q has seen the button low.
   assign launch = (state_q == IDLE) && fire_btn && !fire_q && armed_q;

   // One extra bit keeps grid_top+ROWS-1 from wrapping back into the field.
   assign y_ext    = {1'b0, m_y};
   assign top_ext  = {1'b0, grid_top};
   assign bot_ext  = top_ext + (Y_W+1)'(ROWS - 1);
   assign row_off  = y_ext - top_ext;
   assign in_range = (y_ext >= top_ext) && (y_ext <= bot_ext);

   // One-hot selection of the alien cell under the missile.
   // NOTE: every variable written in always_comb is given a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      target = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (in_range && row_off == (Y_W+1)'(r) && m_col == COL_W'(c))
               target[r*COLS + c] = 1'b1;
         end
      end
   end

   // Dead aliens are transparent: only a live one under the missile counts.
   assign collide = |(target & alive_vec);

   always_comb begin
      state_d  = state_q;
      m_col_d  = m_col;
      m_y_d    = m_y;
      hit_d    = '0;
      miss_d   = 1'b0;
      active_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d  = FLY;
               m_col_d  = player_col;
               m_y_d    = Y_W'(FIELD_H - 1);
               active_d = 1'b1;
            end
         end
         FLY: begin
            active_d = 1'b1;
            // Collision wins over a step that lands in the same cycle.
            if (collide) begin
               state_d  = HIT;
               hit_d    = target;
               active_d = 1'b0;
            end else if (step) begin
               if (m_y == '0) begin
                  state_d  = IDLE;
                  miss_d   = 1'b1;
                  active_d = 1'b0;
               end else begin
                  m_y_d = m_y - 1'b1;
               end
            end
         end
         HIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fire_q  <= 1'b0;
         armed_q <= 1'b0;
         hit     <= '0;
         miss    <= 1'b0;
         active  <= 1'b0;
         m_col   <= '0;
         m_y     <= '0;
      end else begin
         state_q <= state_d;
         fire_q  <= fire_btn;
         armed_q <= armed_q | ~fire_btn;
         hit     <= hit_d;
         miss    <= miss_d;
         active  <= active_d;
         m_col   <= m_col_d;
         m_y     <= m_y_d;
      end
   end

endmodule

// File: tb/tb_missile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_missile_ctrl
// Directed scenarios with randomized tick timing, then a random soak, all
// compared every cycle against a behavioural model of the missile game rules.
// ---------------------------------------------------------------------------
module tb_missile_ctrl;

   localparam int COLS    = game_pkg::COLS;
   localparam int ROWS    = game_pkg::ROWS;
   localparam int FIELD_H = game_pkg::FIELD_H;
   localparam int STEP    = 4;
   localparam int N       = ROWS * COLS;
   localparam int COL_W   = $clog2(COLS);
   localparam int Y_W     = $clog2(FIELD_H);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tick = 1'b0;
   logic             fire_btn = 1'b0;
   logic [COL_W-1:0] player_col = '0;
   logic [Y_W-1:0]   grid_top = '0;
   logic [N-1:0]     alive_vec = '0;
   logic [N-1:0]     hit;
   logic             miss, active;
   logic [COL_W-1:0] m_col;
   logic [Y_W-1:0]   m_y;

   always #5 clk = ~clk;

   missile_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIELD_H(FIELD_H), .STEP_DIV(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .fire_btn   (fire_btn),
      .player_col (player_col),
      .grid_top   (grid_top),
      .alive_vec  (alive_vec),
      .hit        (hit),
      .miss       (miss),
      .active     (active),
      .m_col      (m_col),
      .m_y        (m_y)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           md_fly;       // missile in the air
   bit           md_kill;      // kill pulse currently showing
   int           md_col, md_y, md_ticks;
   bit           md_prev, md_seen_low;
   logic [N-1:0] ex_hit;
   bit           ex_miss;

   task automatic model_step();
      int row;
      ex_hit  = '0;
      ex_miss = 1'b0;
      if (rst) begin
         md_fly = 0; md_kill = 0; md_col = 0; md_y = 0; md_ticks = 0;
         md_prev = 0; md_seen_low = 0;
         return;
      end
      if (md_kill) begin
         md_kill = 0;
      end else if (md_fly) begin
         row = md_y - int'(grid_top);
         if (row >= 0 && row < ROWS && alive_vec[row*COLS + md_col]) begin
            md_fly  = 0;
            md_kill = 1;
            ex_hit[row*COLS + md_col] = 1'b1;
         end else if (tick) begin
            md_ticks++;
            if (md_ticks == STEP) begin
               md_ticks = 0;
               if (md_y == 0) begin
                  md_fly  = 0;
                  ex_miss = 1'b1;
               end else begin
                  md_y--;
               end
            end
         end
      end else if (fire_btn && !md_prev && md_seen_low) begin
         md_fly   = 1;
         md_col   = int'(player_col);
         md_y     = FIELD_H - 1;
         md_ticks = 0;
      end
      md_prev = fire_btn;
      if (!fire_btn) md_seen_low = 1;
   endtask

   // ---------------- cycle driver ----------------
   int fly_ticks;
   bit any_hit;

   task automatic cycle();
      if (active && tick) fly_ticks++;
      model_step();
      @(posedge clk);
      #1;
      if (hit != 0) any_hit = 1;
      check("hit",    hit,    ex_hit);
      check("miss",   miss,   ex_miss);
      check("active", active, md_fly);
      check("m_col",  m_col,  md_col);
      check("m_y",    m_y,    md_y);
   endtask

   task automatic fly_cycle();
      tick = ($urandom_range(0, 2) == 0);
      cycle();
   endtask

   task automatic launch();
      tick = 1'b0;
      fire_btn = 1'b0;
      cycle();
      fire_btn = 1'b1;
      cycle();
      check("launch_active", active, 1);
      fly_ticks = 0;
      any_hit = 0;
   endtask

   task automatic fly_to_y(input int y);
      int n = 0;
      while (!(active && m_y == y) && n < 2000) begin
         fly_cycle();
         n++;
      end
      if (n >= 2000) check("timeout_fly_to_y", 0, 1);
   endtask

   task automatic fly_until_end();
      int n = 0;
      while (active && n < 2000) begin
         fly_cycle();
         n++;
      end
      if (n >= 2000) check("timeout_flight", 0, 1);
   endtask

   logic [63:0] one = 64'd1;

   initial begin
      // ---- reset ----
      rst = 1'b1;
      cycle();
      cycle();
      check("rst_hit", hit, 0);
      check("rst_active", active, 0);
      check("rst_m_y", m_y, 0);
      rst = 1'b0;

      // ---- hit at y=5, idx 27 ----
      grid_top = 4'd2; alive_vec = '1; player_col = 3'd3;
      launch();
      check("A_launch_y", m_y, FIELD_H - 1);
      fly_to_y(5);
      check("A_ticks_to_y5", fly_ticks, 40);
      tick = 1'b1;
      cycle();
      check("A_hit27", hit, one << 27);
      check("A_y_at_hit", m_y, 5);
      check("A_active_in_hit", active, 0);
      tick = 1'b0;
      cycle();
      check("A_hit_cleared", hit, 0);

      // ---- miss: nothing alive ----
      alive_vec = '0; grid_top = 4'($urandom_range(0, 15)); player_col = 3'($urandom_range(0, 7));
      launch();
      fly_until_end();
      check("B_miss", miss, 1);
      check("B_ticks", fly_ticks, 64);
      check("B_no_hit", any_hit, 0);
      cycle();
      check("B_miss_one_cycle", miss, 0);

      // ---- pass through dead alien 27, kill 19 at y=4 ----
      alive_vec = '1; alive_vec[27] = 1'b0; grid_top = 4'd2; player_col = 3'd3;
      launch();
      fly_until_end();
      check("C_hit19", hit, one << 19);
      check("C_y", m_y, 4);
      cycle();

      // ---- fire activity during flight ----
      alive_vec = '0; grid_top = 4'($urandom_range(0, 15));
      launch();
      while (active && m_y > 3) begin
         fire_btn = 1'($urandom);
         fly_cycle();
      end
      fire_btn = 1'b1;
      fly_until_end();
      check("D_missed", miss, 1);
      for (int i = 0; i < 6; i++) cycle();
      check("D_held_no_relaunch", active, 0);
      fire_btn = 1'b0;
      cycle();
      fire_btn = 1'b1;
      cycle();
      check("D_relaunch", active, 1);
      fire_btn = 1'b0;
      fly_until_end();
      cycle();

      // ---- collision and step tick in the same cycle ----
      alive_vec = '1; alive_vec[27] = 1'b0; alive_vec[19] = 1'b0; grid_top = 4'd2; player_col = 3'd3;
      launch();
      fly_to_y(5);
      for (int i = 0; i < STEP - 1; i++) begin
         tick = 1'b1;
         cycle();
      end
      check("E_still_y5", m_y, 5);
      alive_vec[27] = 1'b1;
      tick = 1'b1;
      cycle();
      check("E_hit27", hit, one << 27);
      check("E_y_stays", m_y, 5);
      check("E_no_miss", miss, 0);
      tick = 1'b0;
      cycle();

      // ---- reset mid-flight with button held ----
      alive_vec = '0;
      launch();
      fly_to_y(9);
      rst = 1'b1;
      cycle();
      check("F_active", active, 0);
      check("F_m_y", m_y, 0);
      check("F_hit", hit, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) fly_cycle();
      check("F_no_launch", active, 0);
      fire_btn = 1'b0;
      cycle();

      // ---- random soak ----
      for (int i = 0; i < 6000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 9) == 0) fire_btn = ~fire_btn;
         tick = ($urandom_range(0, 1) == 0);
         player_col = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) grid_top = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) alive_vec = N'($urandom) & N'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
